// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32 core: sequences fetch/decode/execute/memory/writeback.
// Optional: define ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegalInstr); otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int unsigned WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        op,
  input  logic              aluFlag,
  input  logic              memReady,
  output logic              memReq,
  output logic              memWrite,
  output logic              irWrite,
  output logic              pcWrite,
  output logic              adrSrc,
  output logic              regWrite,
  output logic [1:0]        aluSrcA,
  output logic [1:0]        aluSrcB,
  output logic [1:0]        resultSrc,
  output logic [1:0]        immSrc,
  output logic [1:0]        aluOp,
  output logic              instrDone,
`ifdef ILLEGAL_TRAP_EN
  output logic              illegalInstr,
`endif
  output logic [WAIT_W-1:0] stallCnt
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  state_t state;
  logic   op_known;

  always_comb begin
    op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BR) || (op == OP_JAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      stallCnt <= '0;
    end else begin
      if (memReq && !memReady && stallCnt != '1)
        stallCnt <= stallCnt + WAIT_W'(1);
      case (state)
        S_FETCH:    if (memReady) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECR;
            OP_I:         state <= S_EXECI;
            OP_BR:        state <= S_BRANCH;
            OP_JAL:       state <= S_JAL;
`ifdef ILLEGAL_TRAP_EN
            default:      state <= S_TRAP;
`else
            default:      state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (memReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (memReady) state <= S_FETCH;
        S_EXECR,
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; only irWrite/pcWrite/instrDone look at memReady/aluFlag/op.
  always_comb begin
    memReq    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    adrSrc    = 1'b0;
    regWrite  = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    resultSrc = 2'b00;
    aluOp     = 2'b00;
    instrDone = 1'b0;
    case (state)
      S_FETCH: begin
        memReq    = 1'b1;
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        irWrite   = memReady;
        pcWrite   = memReady;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
`ifndef ILLEGAL_TRAP_EN
        instrDone = !op_known;
`endif
      end
      S_MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      S_MEMREAD: begin
        memReq = 1'b1;
        adrSrc = 1'b1;
      end
      S_MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        memReq    = 1'b1;
        memWrite  = 1'b1;
        adrSrc    = 1'b1;
        instrDone = memReady;
      end
      S_EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      S_EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        pcWrite   = aluFlag;
        instrDone = 1'b1;
      end
      S_JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BR:   immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  always_comb illegalInstr = (state == S_TRAP);
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32 core. It sits directly upstream of the ALU decoder.
- Decodes `op[6:0]` from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives `aluOp[1:0]` to the ALU decoder plus all datapath mux selects and write enables.
- Stalls on a memory ready handshake.

Parameters:
- WAIT_W, 8, width of the saturating memory-stall counter `stallCnt`.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- op  input  7  instruction opcode, `instr[6:0]` from the instruction register
- aluFlag  input  1  ALU branch flag: 1 = equal for BEQ control, 1 = less-than for BLT control
- memReady  input  1  memory completes the current request this cycle
- memReq  output  1  memory request active
- memWrite  output  1  memory write strobe
- irWrite  output  1  instruction register load
- pcWrite  output  1  PC load
- adrSrc  output  1  address mux: 0 = PC, 1 = aluOut
- regWrite  output  1  register file write enable
- aluSrcA  output  2  00 = PC, 01 = oldPC, 10 = rd1
- aluSrcB  output  2  00 = rd2, 01 = imm, 10 = constant 4
- resultSrc  output  2  00 = aluOut, 01 = memData, 10 = aluResult
- immSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J
- aluOp  output  2  to ALU decoder: 00 = add, 01 = branch compare, 10 = funct-decoded
- instrDone  output  1  one-cycle pulse in the final cycle of each instruction
- stallCnt  output  WAIT_W  saturating count of stall cycles (`memReq` && !`memReady`)

Behaviour:
- State register is 4 bits, reset asynchronously to FETCH. It is the only state besides `stallCnt`.
- Outputs are Moore (decoded from state), except: `immSrc` decodes from `op`; `irWrite`/`pcWrite`/`instrDone` gated by `memReady` or `aluFlag` as listed.
- Unlisted outputs are 0. `aluOp` is 00 unless stated. `immSrc` is 00 for unknown `op`.
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - branch 1100011
  - jal 1101111
- FETCH:
  - Outputs: `memReq`=1, `adrSrc`=0, `aluSrcA`=00, `aluSrcB`=10, `resultSrc`=10.
  - If `memReady`: `irWrite`=1, `pcWrite`=1, next state DECODE. Else hold.
- DECODE:
  - Outputs: `aluSrcA`=01, `aluSrcB`=01, `aluOp`=00 (branch target computed).
  - Next state by `op`:
    - lw/sw -> MEMADR
    - R -> EXECR
    - I-ALU -> EXECI
    - branch -> BRANCH
    - jal -> JAL
    - other -> see Optional Feature
- MEMADR:
  - Outputs: `aluSrcA`=10, `aluSrcB`=01.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Outputs: `memReq`=1, `adrSrc`=1, `resultSrc`=00.
  - If `memReady` -> MEMWB, else hold.
- MEMWB:
  - Outputs: `resultSrc`=01, `regWrite`=1, `instrDone`=1.
  - Next state FETCH.
- MEMWRITE:
  - Outputs: `memReq`=1, `memWrite`=1, `adrSrc`=1, `resultSrc`=00.
  - If `memReady`: `instrDone`=1, next state FETCH. Else hold.
- EXECR:
  - Outputs: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=10.
  - Next state ALUWB.
- EXECI:
  - Outputs: `aluSrcA`=10, `aluSrcB`=01, `aluOp`=10.
  - Next state ALUWB.
- ALUWB:
  - Outputs: `resultSrc`=00, `regWrite`=1, `instrDone`=1.
  - Next state FETCH.
- BRANCH:
  - Outputs: `aluSrcA`=10, `aluSrcB`=00, `aluOp`=01, `resultSrc`=00.
  - `pcWrite` = `aluFlag`; `instrDone`=1.
  - Next state FETCH.
- JAL:
  - Outputs: `aluSrcA`=01, `aluSrcB`=10, `resultSrc`=00, `pcWrite`=1.
  - Next state ALUWB (writes PC+4 to rd).
- Latencies, no stall (cycles):
  - lw 5
  - sw 4
  - R/I 4
  - branch 3
  - jal 4
- Each memory wait cycle adds 1.
- `stallCnt`:
  - Reset 0.
  - Increments every cycle `memReq`=1 and `memReady`=0.
  - Saturates at all-ones; no wrap.
- Reset mid-instruction: state returns to FETCH immediately (asynchronous). The pending request is abandoned and `stallCnt` clears.
- Reset values (FETCH, `memReady`=0):
  - `memReq`=1, `aluSrcB`=10, `resultSrc`=10
  - all other outputs 0, `stallCnt`=0
- `memReady` outside a `memReq` state is ignored.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - An unknown `op` in DECODE -> TRAP state.
  - TRAP asserts all enables 0 and holds forever until `rst`.
  - Additional output port `illegalInstr` (1 bit) is 1 while in TRAP, reset 0.
- Undefined:
  - An unknown `op` in DECODE -> FETCH with `instrDone`=1 (executes as a NOP, latency 2).
  - No `illegalInstr` port.

Test Plan:
- Reset, hold `memReady`=0 for 3 cycles -> outputs stay at reset values, `stallCnt`=3. Assert `rst` -> `stallCnt`=0 asynchronously.
- R-type (`op`=0110011), `memReady`=1 always -> states FETCH, DECODE, EXECR, ALUWB. `aluOp`=10 only in EXECR. `regWrite` and `instrDone` only in cycle 4.
- lw with `memReady` low for 2 cycles in MEMREAD -> 7 cycles total, `stallCnt` +2, `regWrite` with `resultSrc`=01 in last cycle. sw with `memReady`=1 -> `memWrite` for exactly one cycle, no `regWrite`.
- Branch, `aluFlag`=1 -> `pcWrite`=1 in the BRANCH cycle with `aluOp`=01. `aluFlag`=0 -> `pcWrite`=0. Both cases total 3 cycles.
- jal -> JAL cycle `pcWrite`=1, `aluSrcA`=01, `aluSrcB`=10, then ALUWB `regWrite`=1.
- `op`=1111111: with ILLEGAL_TRAP_EN -> `illegalInstr`=1 held until `rst`, no further `memReq`. Without ILLEGAL_TRAP_EN -> back to FETCH after 2 cycles.
